// File: rtl/pipe_stage_rv.sv
// Valid/ready pipeline register with optional 2-entry skid, flush and saturating stall counter.
// Latency 1 cycle; backpressure holds the head beat, SKID=1 registers in_ready, SKID=0 passes out_ready through.
module pipe_stage_rv #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_vld;
    logic [DATA_W-1:0] main_dat;
    logic [CTRL_W-1:0] main_ctl;
    logic              skid_vld;
    logic [DATA_W-1:0] skid_dat;
    logic [CTRL_W-1:0] skid_ctl;
    logic              ix;
    logic              ox;

    always_comb begin
        in_ready = 1'b0;
        if (SKID != 0) begin
            in_ready = !skid_vld && !reset;
        end else begin
            in_ready = !reset && (!main_vld || out_ready);
        end
    end

    assign ix        = in_valid & in_ready;
    assign ox        = main_vld & out_ready;
    assign out_valid = main_vld;
    assign out_data  = main_dat;
    assign out_ctrl  = main_vld ? main_ctl : '0;

    // Entry valids encode the state: EMPTY (none), ONE (main), FULL (main+skid).
    always_ff @(posedge clk) begin
        if (reset) begin
            main_vld <= 1'b0;
            main_dat <= '0;
            main_ctl <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
            skid_ctl <= '0;
        end else if (flush) begin
            // Payloads are left in place; only valids and control bits are squashed.
            main_vld <= 1'b0;
            main_ctl <= '0;
            skid_vld <= 1'b0;
            skid_ctl <= '0;
        end else if (skid_vld) begin
            if (ox) begin
                main_dat <= skid_dat;
                main_ctl <= skid_ctl;
                skid_vld <= 1'b0;
                skid_ctl <= '0;
            end
        end else if (main_vld) begin
            if (ix && ox) begin
                main_dat <= in_data;
                main_ctl <= in_ctrl;
            end else if (ix && (SKID != 0)) begin
                skid_vld <= 1'b1;
                skid_dat <= in_data;
                skid_ctl <= in_ctrl;
            end else if (ox) begin
                main_vld <= 1'b0;
                main_ctl <= '0;
            end
        end else if (ix) begin
            main_vld <= 1'b1;
            main_dat <= in_data;
            main_ctl <= in_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (main_vld && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
